seq_divider: RTL and testbench

- Sequential signed restoring divider; the inverse companion of the Karatsuba multiplier in the Multiply block.
- Divides a 32-bit two's-complement dividend (a multiplier Product) by a 16-bit two's-complement divisor.
- Returns a 16-bit quotient truncated toward zero, a 16-bit remainder, and error flags.
- Uses the same Start/Done level handshake as the multipliers, so a controller can drive either unit.

---
 rtl/seq_divider_pkg.sv | 24 ++
 rtl/div_step.sv | 26 ++
 rtl/seq_divider.sv | 141 ++++++++++++++
 tb/tb_seq_divider.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential signed divider: FSM encoding and
// quotient saturation values.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 16;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] ITER = 3'd2;
  localparam logic [2:0] FIX  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = IDLE,
    ST_LOAD = LOAD,
    ST_ITER = ITER,
    ST_FIX  = FIX,
    ST_DONE = DONE
  } state_t;

  localparam logic [15:0] Q_POS_SAT = 16'h7FFF;
  localparam logic [15:0] Q_NEG_SAT = 16'h8000;

endpackage

// File: rtl/div_step.sv
// One restoring-division step on unsigned magnitudes.
// Combinational, zero latency; no flow control.
// Shifts {prem, quo} left, trial-subtracts dvs and keeps the result if non-negative.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   prem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   prem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             ge;

  always_comb begin
    shifted  = {prem, quo[WIDTH-1]};
    diff     = shifted - {2'b00, dvs};
    ge       = ~diff[WIDTH+1];
    prem_nxt = ge ? diff[WIDTH:0] : shifted[WIDTH:0];
    quo_nxt  = {quo[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor.
// Latency: Done rises 2 edges after Start is sampled for error cases, 19 otherwise.
// Level handshake: Done holds until Start drops; Start held high never retriggers.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [2*WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0]   Divisor,
  output logic [WIDTH-1:0]   Quotient,
  output logic [WIDTH-1:0]   Remainder,
  output logic               Overflow,
  output logic               DivByZero,
  output logic               Done
);

  localparam int DW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [DW-1:0]      dvd_r;
  logic [WIDTH-1:0]   dvs_r;
  logic [WIDTH-1:0]   dvs_mag;
  logic [WIDTH:0]     prem;
  logic [WIDTH-1:0]   quo;
  logic [CNT_W-1:0]   cnt;
  logic               sign_q;
  logic               dvd_neg;

  logic [DW-1:0]      dvd_abs;
  logic [WIDTH-1:0]   dvs_abs;
  logic               res_sign;
  logic [WIDTH:0]     prem_nxt;
  logic [WIDTH-1:0]   quo_nxt;

  always_comb begin
    dvd_abs  = dvd_r[DW-1] ? -dvd_r : dvd_r;
    dvs_abs  = dvs_r[WIDTH-1] ? -dvs_r : dvs_r;
    res_sign = dvd_r[DW-1] ^ dvs_r[WIDTH-1];
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .prem     (prem),
    .quo      (quo),
    .dvs      (dvs_mag),
    .prem_nxt (prem_nxt),
    .quo_nxt  (quo_nxt)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      dvd_r     <= '0;
      dvs_r     <= '0;
      dvs_mag   <= '0;
      prem      <= '0;
      quo       <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
      dvd_neg   <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      Overflow  <= 1'b0;
      DivByZero <= 1'b0;
      Done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            dvd_r <= Dividend;
            dvs_r <= Divisor;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          sign_q  <= res_sign;
          dvd_neg <= dvd_r[DW-1];
          dvs_mag <= dvs_abs;
          cnt     <= '0;
          if (dvs_r == '0) begin
            DivByZero <= 1'b1;
            Overflow  <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            state     <= ST_DONE;
          end else if (dvd_abs[DW-1:WIDTH] >= dvs_abs) begin
            // Quotient magnitude would need more than WIDTH bits: saturate now.
            Overflow  <= 1'b1;
            DivByZero <= 1'b0;
            Remainder <= '0;
            Quotient  <= res_sign ? Q_NEG_SAT : Q_POS_SAT;
            state     <= ST_DONE;
          end else begin
            prem  <= {1'b0, dvd_abs[DW-1:WIDTH]};
            quo   <= dvd_abs[WIDTH-1:0];
            state <= ST_ITER;
          end
        end
        ST_ITER: begin
          prem <= prem_nxt;
          quo  <= quo_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_STEP) state <= ST_FIX;
        end
        ST_FIX: begin
          DivByZero <= 1'b0;
          if (!sign_q && quo[WIDTH-1]) begin
            Overflow  <= 1'b1;
            Quotient  <= Q_POS_SAT;
            Remainder <= '0;
          end else if (sign_q && quo[WIDTH-1] && (|quo[WIDTH-2:0])) begin
            Overflow  <= 1'b1;
            Quotient  <= Q_NEG_SAT;
            Remainder <= '0;
          end else begin
            Overflow  <= 1'b0;
            Quotient  <= sign_q ? -quo : quo;
            Remainder <= dvd_neg ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
          end
          state <= ST_DONE;
        end
        ST_DONE: begin
          // Done is raised for at least one cycle even if Start has already dropped.
          Done <= 1'b1;
          if (Done && !Start) begin
            Done  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [31:0] Dividend;
  logic [15:0] Divisor;
  logic [15:0] Quotient;
  logic [15:0] Remainder;
  logic        Overflow;
  logic        DivByZero;
  logic        Done;

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  seq_divider dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Overflow  (Overflow),
    .DivByZero (DivByZero),
    .Done      (Done)
  );

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed arithmetic, truncating division, saturation on range.
  task automatic model(input logic [31:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic ov, output logic dz, output int lat);
    longint la, lb, lq, lr, aa, ab;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    q = 16'h0; r = 16'h0; ov = 1'b0; dz = 1'b0; lat = 19;
    if (lb == 0) begin
      dz  = 1'b1;
      lat = 2;
    end else begin
      lq = la / lb;
      lr = la % lb;
      aa = (la < 0) ? -la : la;
      ab = (lb < 0) ? -lb : lb;
      if (aa >= ab * 65536) lat = 2;
      if (lq > 32767) begin
        ov = 1'b1; q = 16'h7FFF;
      end else if (lq < -32768) begin
        ov = 1'b1; q = 16'h8000;
      end else begin
        q = lq[15:0];
        r = lr[15:0];
      end
    end
  endtask

  // Start an operation and return the edge index (Start-sampling edge = 0) where Done rose.
  task automatic run_op(input logic [31:0] a, input logic [15:0] b, output int lat);
    @(negedge Clock);
    Dividend = a;
    Divisor  = b;
    Start    = 1'b1;
    @(posedge Clock);
    #1;
    Dividend = $urandom;
    Divisor  = 16'($urandom);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge Clock);
      #1;
      if (Done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic finish_op(input string tag);
    logic [33:0] held;
    held = {Quotient, Remainder, Overflow, DivByZero};
    @(negedge Clock);
    Start = 1'b0;
    @(posedge Clock);
    #1;
    chk({tag, "_done_fall"}, Done, 1'b0);
    chk({tag, "_hold"}, {Quotient, Remainder, Overflow, DivByZero}, held);
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er,
                          input logic eov, input logic edz, input int elat);
    int lat;
    run_op(a, b, lat);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_res"}, {Quotient, Remainder, Overflow, DivByZero}, {eq, er, eov, edz});
  endtask

  logic [31:0] ra;
  logic [15:0] rb;
  logic [15:0] mq, mr;
  logic        mov, mdz;
  int          mlat, lat;
  bit          found;
  longint      sq, sr, sd;

  initial begin
    Reset = 1'b1; Start = 1'b0; Dividend = '0; Divisor = '0;
    repeat (2) @(posedge Clock);
    #1;
    chk("reset_outputs", {Quotient, Remainder, Overflow, DivByZero, Done}, 35'h0);
    @(negedge Clock);
    Reset = 1'b0;

    directed("pos_pos", 32'd1000, 16'd7, 16'h008E, 16'd6, 1'b0, 1'b0, 19);
    // Start held high through DONE must neither drop Done nor restart.
    for (int i = 0; i < 4; i++) begin
      @(posedge Clock);
      #1;
      chk("hold_start_done", {Done, Quotient}, {1'b1, 16'h008E});
    end
    finish_op("pos_pos");
    repeat (3) @(posedge Clock);
    #1;
    chk("idle_no_restart", {Done, Quotient}, {1'b0, 16'h008E});

    directed("neg_pos", -32'sd1000, 16'd7, 16'hFF72, 16'hFFFA, 1'b0, 1'b0, 19);
    finish_op("neg_pos");
    directed("pos_neg", 32'd1000, -16'sd7, 16'hFF72, 16'h0006, 1'b0, 1'b0, 19);
    finish_op("pos_neg");
    directed("neg_sat_edge", -32'sd98304, 16'd3, 16'h8000, 16'h0000, 1'b0, 1'b0, 19);
    finish_op("neg_sat_edge");
    directed("fix_ovf", 32'd100000, 16'd3, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 19);
    finish_op("fix_ovf");
    directed("load_ovf", 32'h7FFFFFFF, 16'd1, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 2);
    finish_op("load_ovf");
    directed("min_by_min", 32'h80000000, 16'h8000, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 2);
    finish_op("min_by_min");
    directed("div_zero", 32'd12345, 16'd0, 16'h0000, 16'h0000, 1'b0, 1'b1, 2);
    finish_op("div_zero");
    directed("after_dz", 32'd10, 16'd3, 16'd3, 16'd1, 1'b0, 1'b0, 19);
    finish_op("after_dz");
    directed("small_neg", -32'sd1, 16'd5, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 19);
    finish_op("small_neg");
    directed("round_trip", -32'sd60000, -16'sd200, 16'd300, 16'd0, 1'b0, 1'b0, 19);
    finish_op("round_trip");

    // Asynchronous reset in the middle of the iteration phase.
    @(negedge Clock);
    Dividend = 32'd1000; Divisor = 16'd7; Start = 1'b1;
    @(posedge Clock);
    repeat (6) @(posedge Clock);
    #1;
    Reset = 1'b1;
    #1;
    chk("mid_iter_reset", {Quotient, Remainder, Overflow, DivByZero, Done}, 35'h0);
    @(negedge Clock);
    Reset = 1'b0;
    Start = 1'b0;
    directed("post_reset", 32'd10, 16'd3, 16'd3, 16'd1, 1'b0, 1'b0, 19);
    finish_op("post_reset");

    for (int n = 0; n < 1000; n++) begin
      found = 1'b0;
      for (int t = 0; t < 200 && !found; t++) begin
        ra = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) ra = -ra;
        rb = 16'($urandom >> $urandom_range(16, 31));
        if ($urandom_range(0, 1) == 1) rb = -rb;
        model(ra, rb, mq, mr, mov, mdz, mlat);
        if (!mov && !mdz) found = 1'b1;
      end
      if (!found) continue;
      run_op(ra, rb, lat);
      chk("rand_lat", lat, mlat);
      chk("rand_res", {Quotient, Remainder, Overflow, DivByZero}, {mq, mr, mov, mdz});
      sq = longint'($signed(Quotient));
      sr = longint'($signed(Remainder));
      sd = longint'($signed(rb));
      chk("rand_identity", sq * sd + sr, longint'($signed(ra)));
      chk("rand_rem_mag", ((sr < 0 ? -sr : sr) < (sd < 0 ? -sd : sd)), 1'b1);
      chk("rand_rem_sign", (sr == 0) || ((sr < 0) == ra[31]), 1'b1);
      @(negedge Clock);
      Start = 1'b0;
      @(posedge Clock);
      #1;
      chk("rand_done_fall", Done, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
